// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline stage register with two-entry skid buffer and NOP flush
module pipe_stage_buf #(
    parameter int NBITS = 32,
    parameter int NCTRL = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [NBITS-1:0] i_data,
    input  logic [NCTRL-1:0] i_ctrl,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [NBITS-1:0] o_data,
    output logic [NCTRL-1:0] o_ctrl,
    output logic [1:0]       o_count
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       r_state;
    logic             r_ready;
    logic [NBITS-1:0] r_main_data;
    logic [NCTRL-1:0] r_main_ctrl;
    logic [NBITS-1:0] r_skid_data;
    logic [NCTRL-1:0] r_skid_ctrl;

    logic [1:0]       w_next_state;
    logic             w_valid;
    logic             w_accept;
    logic             w_deliver;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    assign w_valid   = (r_state == S_ONE) || (r_state == S_TWO);
    assign w_accept  = i_valid & r_ready;
    assign w_deliver = w_valid & i_ready;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            // A deliver in this cycle still completes; everything else is dropped.
            w_next_state = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_next_state   = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_deliver) begin
                        w_next_state   = S_ONE;
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_next_state = S_TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_deliver) begin
                        w_next_state = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_deliver) begin
                        w_next_state     = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_next_state = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state != S_TWO);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= i_data;
                r_main_ctrl <= i_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= i_data;
                r_skid_ctrl <= i_ctrl;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = w_valid;
    assign o_data  = r_main_data;
    assign o_ctrl  = w_valid ? r_main_ctrl : '0;
    assign o_count = r_state;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf with queue reference model
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic [23:0] i_ctrl;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [23:0] o_ctrl;
    logic [1:0]  o_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [55:0] exp_q[$];
    logic acc_now;

    pipe_stage_buf #(.NBITS(32), .NCTRL(24)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .i_ctrl (i_ctrl),
        .i_flush(i_flush),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_ctrl (o_ctrl),
        .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One stimulus cycle: drive after negedge, commit the model after the posedge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic [23:0] c,
                       input logic rdy, input logic fl);
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        i_ctrl  = c;
        i_ready = rdy;
        i_flush = fl;
        acc_now = v & o_ready;
        @(posedge clk);
        #1;
        if (acc_now && !fl) exp_q.push_back({d, c});
    endtask

    // Monitor: occupancy, bubble gating and in-order delivery against the queue.
    initial begin
        logic [55:0] head;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                chk("count_vs_model", 64'(o_count), 64'(exp_q.size()));
                chk("valid_vs_model", 64'(o_valid), 64'(exp_q.size() != 0));
                chk("ready_vs_model", 64'(o_ready), 64'(exp_q.size() < 2));
                if (!o_valid) chk("bubble_ctrl_zero", 64'(o_ctrl), 64'd0);
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {8'd0, o_data, o_ctrl}, 64'hDEAD);
                    end else begin
                        head = exp_q.pop_front();
                        chk("deliver_word", {8'd0, o_data, o_ctrl}, {8'd0, head});
                    end
                end
                if (i_flush) exp_q.delete();
            end
        end
    end

    initial begin
        logic        pv, pacc, pfl;
        logic [31:0] pd;
        logic [23:0] pc;
        logic        v, rdy, fl;
        int          guard;

        rst_n = 1'b1; i_valid = 0; i_data = 0; i_ctrl = 0; i_flush = 0; i_ready = 0;
        acc_now = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_ready", 64'(o_ready), 64'd1);
        chk("reset_count", 64'(o_count), 64'd0);
        chk("reset_ctrl", 64'(o_ctrl), 64'd0);
        chk("reset_data", 64'(o_data), 64'd0);
        @(negedge clk); @(negedge clk);
        #3 rst_n = 1'b1;

        // Back-to-back stream with downstream always ready.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 32'(k), 24'(k * 3), 1'b1, 1'b0);
            chk("stream_count", 64'(o_count), 64'd1);
            chk("stream_ready", 64'(o_ready), 64'd1);
            chk("stream_data", 64'(o_data), 64'(k));
        end
        cyc(1'b0, 0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 0, 1'b1, 1'b0);

        // Stall: skid absorbs the in-flight word, third word held upstream.
        cyc(1'b1, 32'hA, 24'h00000A, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 24'h00000B, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 24'h00000C, 1'b0, 1'b0);
        chk("stall_count", 64'(o_count), 64'd2);
        chk("stall_ready", 64'(o_ready), 64'd0);
        chk("stall_data", 64'(o_data), 64'hA);
        guard = 0;
        acc_now = 0;
        while (!acc_now && guard < 10) begin
            cyc(1'b1, 32'hC, 24'h00000C, 1'b1, 1'b0);
            guard++;
        end
        chk("stall_c_accepted", 64'(acc_now), 64'd1);
        cyc(1'b0, 0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 0, 1'b1, 1'b0);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Flush with a full buffer and a simultaneous offer.
        cyc(1'b1, 32'h11, 24'h000011, 1'b0, 1'b0);
        cyc(1'b1, 32'h12, 24'h000012, 1'b0, 1'b0);
        cyc(1'b1, 32'hD, 24'hFFFFFF, 1'b0, 1'b1);
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ctrl", 64'(o_ctrl), 64'd0);
        chk("flush_count", 64'(o_count), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        cyc(1'b0, 0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 0, 1'b1, 1'b0);

        // Bubble gating: ctrl zeroed, payload retained.
        cyc(1'b1, 32'h55, 24'hFFFFFF, 1'b1, 1'b0);
        chk("bubble_ctrl_live", 64'(o_ctrl), 64'hFFFFFF);
        cyc(1'b0, 0, 0, 1'b1, 1'b0);
        chk("bubble_valid", 64'(o_valid), 64'd0);
        chk("bubble_ctrl", 64'(o_ctrl), 64'd0);
        chk("bubble_data_kept", 64'(o_data), 64'h55);

        // Asynchronous reset mid-cycle with two entries held.
        cyc(1'b1, 32'h21, 24'h000021, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 24'h000022, 1'b0, 1'b0);
        chk("pre_reset_count", 64'(o_count), 64'd2);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_valid", 64'(o_valid), 64'd0);
        chk("midreset_ctrl", 64'(o_ctrl), 64'd0);
        chk("midreset_count", 64'(o_count), 64'd0);
        chk("midreset_ready", 64'(o_ready), 64'd1);
        i_valid = 0; i_flush = 0;
        @(negedge clk);
        #3 rst_n = 1'b1;

        // Randomized traffic; upstream holds an offer until it is accepted.
        pv = 0; pacc = 0; pfl = 0; pd = 0; pc = 0;
        for (int n = 0; n < 10000; n++) begin
            rdy = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 15) == 0);
            if (pv && !pacc && !pfl) begin
                v = 1'b1;
            end else begin
                v  = ($urandom_range(0, 9) < 7);
                pd = $urandom;
                pc = 24'($urandom);
            end
            cyc(v, pd, pc, rdy, fl);
            pv = v; pacc = acc_now; pfl = fl;
        end
        for (int n = 0; n < 4; n++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
